// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, state encodings and helpers for the HD44780 hex display controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lcd_pkg;

    // HD44780 command bytes (RS = 0)
    localparam logic [7:0] FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] DISP_ON  = 8'h0C;  // display on, cursor off, blink off
    localparam logic [7:0] ENTRY    = 8'h06;  // increment address, no shift
    localparam logic [7:0] CLEAR    = 8'h01;  // clear display, needs the long wait
    localparam logic [7:0] LINE1    = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] LINE2    = 8'hC0;  // DDRAM address 0x40

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_X     = 8'h78;

    // Top-level frame sequencer states
    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT,
        S_L1_ADDR,
        S_L1_CHAR,
        S_L2_ADDR,
        S_L2_CHAR,
        S_IDLE
    } lcd_state_t;

    // Single-write bus phases
    typedef enum logic [2:0] {
        W_IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        W_WAIT
    } wr_state_t;

    // Cycle counts derived from a slow clock can round to zero; every phase lasts at least a cycle.
    function automatic int clamp1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return ASCII_ZERO + {4'h0, n};
        else
            return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    // Power-up command order
    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    return FUNC_SET;
            2'd1:    return DISP_ON;
            2'd2:    return ENTRY;
            default: return CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: performs one timed HD44780 write (setup, enable pulse, hold, execution wait).
// Latency: T_SU + T_EN + T_SU + (T_CMD or T_CLR) cycles from start to done.
// Backpressure: start is only accepted while idle=1; done pulses for one cycle as the wait ends.
// Ports: clk_div/rst_n clock and async active-low reset; start/wr_dat/wr_rs/long_wait request;
//        done/idle status; lcd_dat/lcd_rs/lcd_en drive the panel pins.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk_div,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] wr_dat,
    input  logic       wr_rs,
    input  logic       long_wait,
    output logic       done,
    output logic       idle,
    output logic [7:0] lcd_dat,
    output logic       lcd_rs,
    output logic       lcd_en
);

    localparam int T_SU  = clamp1(CLK_HZ / 10_000_000);
    localparam int T_EN  = clamp1(CLK_HZ / 2_000_000);
    localparam int T_CMD = clamp1(CLK_HZ / 25_000);
    localparam int T_CLR = clamp1(CLK_HZ / 500);
    localparam int T_PWR = clamp1(CLK_HZ / 50);
    // Sized for the longest interval in the system so every phase fits one counter.
    localparam int CNT_W = $clog2(T_PWR + 1);

    localparam logic [CNT_W-1:0] LD_SU  = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] LD_EN  = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_CMD = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] LD_CLR = CNT_W'(T_CLR - 1);

    wr_state_t        st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       dat_q, dat_d;
    logic             rs_q, rs_d;
    logic             long_q, long_d;
    logic             en_q, en_d;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        dat_d  = dat_q;
        rs_d   = rs_q;
        long_d = long_q;
        en_d   = en_q;
        done   = 1'b0;
        unique case (st_q)
            W_IDLE: begin
                // The only point where the bus value changes.
                if (start) begin
                    st_d   = W_SETUP;
                    cnt_d  = LD_SU;
                    dat_d  = wr_dat;
                    rs_d   = wr_rs;
                    long_d = long_wait;
                end
            end
            W_SETUP: begin
                if (cnt_zero) begin
                    st_d  = W_PULSE;
                    cnt_d = LD_EN;
                    en_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            W_PULSE: begin
                if (cnt_zero) begin
                    st_d  = W_HOLD;
                    cnt_d = LD_SU;
                    en_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            W_HOLD: begin
                if (cnt_zero) begin
                    st_d  = W_WAIT;
                    cnt_d = long_q ? LD_CLR : LD_CMD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            W_WAIT: begin
                if (cnt_zero) begin
                    st_d = W_IDLE;
                    done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                st_d = W_IDLE;
                en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= W_IDLE;
            cnt_q  <= '0;
            dat_q  <= 8'h00;
            rs_q   <= 1'b0;
            long_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            dat_q  <= dat_d;
            rs_q   <= rs_d;
            long_q <= long_d;
            en_q   <= en_d;
        end
    end

    assign idle    = (st_q == W_IDLE);
    assign lcd_dat = dat_q;
    assign lcd_rs  = rs_q;
    assign lcd_en  = en_q;

endmodule

// File: rtl/lcd_hex_ctrl.sv
// lcd_hex_ctrl: HD44780 16x2 controller; line 1 = live iHEX digits, line 2 = "0x" + latched message.
// Latency: 20 ms power wait + init, then continuous 34-write frames; iMSG_LD shows within 2 frames.
// Backpressure: none; iHEX/iMSG are sampled (snapshot per line), the panel is write-only.
// Ports: iCLK/iRST_N clock and async active-low reset; iHEX live value; iMSG/iMSG_LD message load;
//        oREADY init done; LCD_* panel pins (RW tied 0, ON/BLON tied 1).
// Option: define LCD_DIRTY_REFRESH_EN to idle between frames and refresh only on change.
module lcd_hex_ctrl
    import lcd_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int NUM_HEX = 4,
    parameter int MSG_W   = 16
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic [4*NUM_HEX-1:0] iHEX,
    input  logic [MSG_W-1:0]     iMSG,
    input  logic                 iMSG_LD,
    output logic                 oREADY,
    output logic [7:0]           LCD_DATA,
    output logic                 LCD_RS,
    output logic                 LCD_RW,
    output logic                 LCD_EN,
    output logic                 LCD_ON,
    output logic                 LCD_BLON
);

    localparam int HEX_W  = 4 * NUM_HEX;
    localparam int NMSG   = MSG_W / 4;
    localparam int L1_PAD = 16 - NUM_HEX;
    localparam int T_PWR  = clamp1(CLK_HZ / 50);
    localparam int CNT_W  = $clog2(T_PWR + 1);
    localparam logic [CNT_W-1:0] LD_PWR = CNT_W'(T_PWR - 1);

    lcd_state_t       st_q, st_d;
    logic [3:0]       idx_q, idx_d;      // init step or character column
    logic [CNT_W-1:0] pwr_q, pwr_d;
    logic [HEX_W-1:0] hex_snap_q;
    logic [MSG_W-1:0] msg_q;
    logic [MSG_W-1:0] msg_snap_q;
    logic             ready_q;

    logic             snap_l1, snap_l2, ready_set;
    logic             wr_start, wr_rs, wr_long, wr_done, wr_idle;
    logic [7:0]       wr_dat;

    logic [3:0]       l1_nib, l2_nib;
    logic [7:0]       l1_char, l2_char;
    int               l1_pos, l2_pos;

`ifdef LCD_DIRTY_REFRESH_EN
    // Remembers a message load until the line-2 snapshot that will display it.
    logic             ld_pend_q;
`endif

    // Line 1: right-aligned digits, MSB first, space padded on the left.
    always_comb begin
        l1_pos  = int'(idx_q) - L1_PAD;
        l1_nib  = 4'h0;
        l1_char = ASCII_SPACE;
        for (int k = 0; k < NUM_HEX; k++) begin
            if (l1_pos == k) l1_nib = hex_snap_q[4*(NUM_HEX-1-k) +: 4];
        end
        if (l1_pos >= 0) l1_char = hex_to_ascii(l1_nib);
    end

    // Line 2: "0x" prefix, digits MSB first, space padded on the right.
    always_comb begin
        l2_pos  = int'(idx_q) - 2;
        l2_nib  = 4'h0;
        l2_char = ASCII_SPACE;
        for (int k = 0; k < NMSG; k++) begin
            if (l2_pos == k) l2_nib = msg_snap_q[MSG_W-4-4*k +: 4];
        end
        if (idx_q == 4'd0)
            l2_char = ASCII_ZERO;
        else if (idx_q == 4'd1)
            l2_char = ASCII_X;
        else if (l2_pos < NMSG)
            l2_char = hex_to_ascii(l2_nib);
    end

    // Next state. Every write state advances on the writer's done pulse.
    always_comb begin
        st_d      = st_q;
        idx_d     = idx_q;
        pwr_d     = pwr_q;
        snap_l1   = 1'b0;
        snap_l2   = 1'b0;
        ready_set = 1'b0;
        unique case (st_q)
            S_PWR_WAIT: begin
                if (pwr_q == '0) st_d = S_INIT;
                else             pwr_d = pwr_q - 1'b1;
            end
            S_INIT: begin
                if (wr_done) begin
                    if (idx_q == 4'd3) begin
                        st_d      = S_L1_ADDR;
                        idx_d     = 4'd0;
                        snap_l1   = 1'b1;
                        ready_set = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_L1_ADDR: begin
                if (wr_done) begin
                    st_d  = S_L1_CHAR;
                    idx_d = 4'd0;
                end
            end
            S_L1_CHAR: begin
                if (wr_done) begin
                    if (idx_q == 4'd15) begin
                        st_d    = S_L2_ADDR;
                        idx_d   = 4'd0;
                        snap_l2 = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_L2_ADDR: begin
                if (wr_done) begin
                    st_d  = S_L2_CHAR;
                    idx_d = 4'd0;
                end
            end
            S_L2_CHAR: begin
                if (wr_done) begin
                    if (idx_q == 4'd15) begin
                        idx_d = 4'd0;
`ifdef LCD_DIRTY_REFRESH_EN
                        if (ld_pend_q || iMSG_LD) begin
                            st_d    = S_L1_ADDR;
                            snap_l1 = 1'b1;
                        end else begin
                            st_d = S_IDLE;
                        end
`else
                        st_d    = S_L1_ADDR;
                        snap_l1 = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef LCD_DIRTY_REFRESH_EN
            S_IDLE: begin
                if ((iHEX != hex_snap_q) || ld_pend_q) begin
                    st_d    = S_L1_ADDR;
                    snap_l1 = 1'b1;
                end
            end
`endif
            default: begin
                st_d  = S_PWR_WAIT;
                idx_d = 4'd0;
                pwr_d = LD_PWR;
            end
        endcase
    end

    // Write request for the current state; issued whenever the writer is idle.
    always_comb begin
        wr_start = 1'b0;
        wr_dat   = 8'h00;
        wr_rs    = 1'b0;
        wr_long  = 1'b0;
        unique case (st_q)
            S_INIT: begin
                wr_start = wr_idle;
                wr_dat   = init_cmd(idx_q[1:0]);
                wr_long  = (idx_q == 4'd3);
            end
            S_L1_ADDR: begin
                wr_start = wr_idle;
                wr_dat   = LINE1;
            end
            S_L1_CHAR: begin
                wr_start = wr_idle;
                wr_dat   = l1_char;
                wr_rs    = 1'b1;
            end
            S_L2_ADDR: begin
                wr_start = wr_idle;
                wr_dat   = LINE2;
            end
            S_L2_CHAR: begin
                wr_start = wr_idle;
                wr_dat   = l2_char;
                wr_rs    = 1'b1;
            end
            default: begin
                wr_start = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            st_q       <= S_PWR_WAIT;
            idx_q      <= 4'd0;
            pwr_q      <= LD_PWR;
            hex_snap_q <= '0;
            msg_q      <= '0;
            msg_snap_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            st_q  <= st_d;
            idx_q <= idx_d;
            pwr_q <= pwr_d;
            if (iMSG_LD)   msg_q      <= iMSG;
            if (snap_l1)   hex_snap_q <= iHEX;
            // Takes the pre-load value if a load lands on the same edge; it shows next frame.
            if (snap_l2)   msg_snap_q <= msg_q;
            if (ready_set) ready_q    <= 1'b1;
        end
    end

`ifdef LCD_DIRTY_REFRESH_EN
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)      ld_pend_q <= 1'b0;
        else if (iMSG_LD) ld_pend_q <= 1'b1;
        else if (snap_l2) ld_pend_q <= 1'b0;
    end
`endif

    lcd_bus_writer #(
        .CLK_HZ (CLK_HZ)
    ) u_writer (
        .clk_div   (iCLK),
        .rst_n     (iRST_N),
        .start     (wr_start),
        .wr_dat    (wr_dat),
        .wr_rs     (wr_rs),
        .long_wait (wr_long),
        .done      (wr_done),
        .idle      (wr_idle),
        .lcd_dat   (LCD_DATA),
        .lcd_rs    (LCD_RS),
        .lcd_en    (LCD_EN)
    );

    assign oREADY   = ready_q;
    assign LCD_RW   = 1'b0;
    assign LCD_ON   = 1'b1;
    assign LCD_BLON = 1'b1;

endmodule
